// File: rtl/apb_slave_pkg.sv
// Shared types and default widths for the APB completer memory block.
package apb_slave_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] data;
        logic                  write;
    } apb_req_t;

endpackage

// File: rtl/apb_slave_regfile.sv
// Byte-wide storage for apb_slave_mem: synchronous write, combinational read, no reset.
module apb_slave_regfile #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a register memory with programmable wait states.
// Optional read-only top region enabled by `define APB_SLV_RO_REGION_EN (adds RO_BASE).
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned MEM_DEPTH   = 64,
`ifdef APB_SLV_RO_REGION_EN
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned RO_BASE     = MEM_DEPTH - 8
`else
    parameter int unsigned WAIT_CYCLES = 0
`endif
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    apb_state_e        state_q;
    apb_req_t          req_q;
    logic              err_q;
    logic [3:0]        cnt_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [DATA_W-1:0] prdata_q;

    logic              setup_now;
    logic              done;
    logic              capture;
    logic              wr_en;
    logic              ro_hit;
    logic              new_err;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_val;

    assign setup_now = PSEL & ~PENABLE;
    assign done      = (state_q != IDLE) & pready_q;
    assign capture   = setup_now & ((state_q == IDLE) | done);
    assign wr_en     = done & ~pslverr_q & req_q.write & PRESETn;

`ifdef APB_SLV_RO_REGION_EN
    assign ro_hit = PWRITE & (32'(PADDR) >= RO_BASE);
`else
    assign ro_hit = 1'b0;
`endif
    assign new_err = (32'(PADDR) >= MEM_DEPTH) | ro_hit;

    // A request captured in the same cycle a write commits must see the new data.
    assign rd_addr = capture ? PADDR : req_q.addr;
    assign rd_val  = (wr_en && (req_q.addr == rd_addr)) ? req_q.data : mem_rdata;

    apb_slave_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk    (PCLK),
        .we     (wr_en),
        .waddr  (req_q.addr[IDX_W-1:0]),
        .wdata  (req_q.data),
        .raddr  (rd_addr[IDX_W-1:0]),
        .rdata  (mem_rdata)
    );

    // PREADY is registered, so the request is latched at the end of the bus SETUP
    // cycle; state SETUP then covers the first ACCESS cycle, ACCESS the later ones.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            req_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            if (capture) begin
                req_q   <= '{addr: PADDR, data: PWDATA, write: PWRITE};
                err_q   <= new_err;
                cnt_q   <= 4'(WAIT_CYCLES);
                state_q <= SETUP;
                if (WAIT_CYCLES == 0) begin
                    pready_q  <= 1'b1;
                    pslverr_q <= new_err;
                    prdata_q  <= (!PWRITE && !new_err) ? rd_val : '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (PSEL && PENABLE) begin
                            state_q     <= ACCESS;
                            err_q       <= 1'b1;
                            cnt_q       <= '0;
                            req_q.write <= 1'b0;
                            pready_q    <= 1'b1;
                            pslverr_q   <= 1'b1;
                        end
                    end
                    SETUP, ACCESS: begin
                        if (done || !(PSEL && PENABLE)) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= ACCESS;
                            cnt_q   <= cnt_q - 4'd1;
                            if (cnt_q == 4'd1) begin
                                pready_q  <= 1'b1;
                                pslverr_q <= err_q;
                                prdata_q  <= (!req_q.write && !err_q) ? rd_val : '0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule
